// File: rtl/vreg_port_arbiter.sv
// vreg_port_arbiter: round-robin two-requester sequencer for the single-port vector register file
module vreg_port_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [1:0]  r0_addr,
    input  logic [63:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_done,
    output logic [63:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [1:0]  r1_addr,
    input  logic [63:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_done,
    output logic [63:0] r1_rdata,
    output logic [1:0]  rf_dir,
    output logic        rf_wren,
    output logic [63:0] rf_wdata,
    input  logic [63:0] rf_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        own_q, own_d;
    logic        pick1;
    logic        r0_gnt_q, r0_gnt_d, r1_gnt_q, r1_gnt_d;
    logic        r0_done_q, r0_done_d, r1_done_q, r1_done_d;
    logic [63:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
    logic [1:0]  dir_q, dir_d;
    logic        wren_q, wren_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q;

    // r1 wins only when it is alone or r0 was the previous owner
    assign pick1 = r1_req && (!r0_req || !last_q);

    // next state: arbitrate in IDLE, then walk the fixed issue/wait/response sequence
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        own_d      = own_q;
        r0_gnt_d   = 1'b0;
        r1_gnt_d   = 1'b0;
        r0_done_d  = 1'b0;
        r1_done_d  = 1'b0;
        r0_rdata_d = r0_rdata_q;
        r1_rdata_d = r1_rdata_q;
        dir_d      = dir_q;
        wren_d     = 1'b0;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    state_d  = ISSUE;
                    own_d    = pick1;
                    last_d   = pick1;
                    r0_gnt_d = !pick1;
                    r1_gnt_d = pick1;
                    dir_d    = pick1 ? r1_addr : r0_addr;
                    wren_d   = pick1 ? r1_we : r0_we;
                    wdata_d  = pick1 ? r1_wdata : r0_wdata;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = 4'(RD_LAT);
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    r0_done_d  = !own_q;
                    r1_done_d  = own_q;
                    r0_rdata_d = own_q ? r0_rdata_q : rf_rdata;
                    r1_rdata_d = own_q ? rf_rdata : r1_rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            own_q      <= 1'b0;
            r0_gnt_q   <= 1'b0;
            r1_gnt_q   <= 1'b0;
            r0_done_q  <= 1'b0;
            r1_done_q  <= 1'b0;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
            dir_q      <= '0;
            wren_q     <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            own_q      <= own_d;
            r0_gnt_q   <= r0_gnt_d;
            r1_gnt_q   <= r1_gnt_d;
            r0_done_q  <= r0_done_d;
            r1_done_q  <= r1_done_d;
            r0_rdata_q <= r0_rdata_d;
            r1_rdata_q <= r1_rdata_d;
            dir_q      <= dir_d;
            wren_q     <= wren_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            busy_q     <= state_d != IDLE;
        end
    end

    assign r0_gnt   = r0_gnt_q;
    assign r1_gnt   = r1_gnt_q;
    assign r0_done  = r0_done_q;
    assign r1_done  = r1_done_q;
    assign r0_rdata = r0_rdata_q;
    assign r1_rdata = r1_rdata_q;
    assign rf_dir   = dir_q;
    assign rf_wren  = wren_q;
    assign rf_wdata = wdata_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_vreg_port_arbiter.sv
// tb_vreg_port_arbiter: scoreboard bench for the vector register file arbiter with a file model
module tb_vreg_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [1:0]  r0_addr = '0, r1_addr = '0;
    logic [63:0] r0_wdata = '0, r1_wdata = '0;
    logic        r0_gnt, r0_done, r1_gnt, r1_done, rf_wren, busy;
    logic [63:0] r0_rdata, r1_rdata, rf_wdata;
    logic [63:0] rf_rdata = '0;
    logic [1:0]  rf_dir;
    logic        b_r1_req = 1'b0, b_r1_we = 1'b0;
    logic [1:0]  b_r1_addr = '0;
    logic [63:0] b_r1_wdata = '0;
    logic        b_r0_gnt, b_r0_done, b_r1_gnt, b_r1_done, b_rf_wren, b_busy;
    logic [63:0] b_r0_rdata, b_r1_rdata, b_rf_wdata;
    logic [63:0] b_rf_rdata = '0;
    logic [1:0]  b_rf_dir;
    logic [63:0] mem_a [4];
    logic [63:0] mem_b [4];
    logic [63:0] cap_a, cap_b;
    logic [63:0] sb0 [$];
    logic [63:0] sb1 [$];
    int          g0 = 0, g1 = 0;

    vreg_port_arbiter #(.RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
        .rf_dir(rf_dir), .rf_wren(rf_wren), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .busy(busy)
    );

    vreg_port_arbiter #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .r0_req(1'b0), .r0_we(1'b0), .r0_addr(2'b00), .r0_wdata(64'h0),
        .r0_gnt(b_r0_gnt), .r0_done(b_r0_done), .r0_rdata(b_r0_rdata),
        .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
        .r1_gnt(b_r1_gnt), .r1_done(b_r1_done), .r1_rdata(b_r1_rdata),
        .rf_dir(b_rf_dir), .rf_wren(b_rf_wren), .rf_wdata(b_rf_wdata), .rf_rdata(b_rf_rdata),
        .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // register file model: posedge write and read capture (read sees the new write), negedge drive
    always @(posedge clk) begin
        if (rf_wren) mem_a[rf_dir] <= rf_wdata;
        cap_a <= rf_wren ? rf_wdata : mem_a[rf_dir];
        if (b_rf_wren) mem_b[b_rf_dir] <= b_rf_wdata;
        cap_b <= b_rf_wren ? b_rf_wdata : mem_b[b_rf_dir];
    end

    always @(negedge clk) begin
        rf_rdata   <= cap_a;
        b_rf_rdata <= cap_b;
    end

    // scoreboard: each done pops that requester's oldest expectation and checks data and latency
    initial begin
        forever begin
            @(negedge clk);
            if (r0_gnt) g0 = cyc;
            if (r1_gnt) g1 = cyc;
            if (r0_done) begin
                total++;
                if (sb0.size() == 0) begin
                    bad++;
                    $display("FAIL r0_done_unexpected rdata=%h", r0_rdata);
                end else begin
                    logic [63:0] e;
                    e = sb0.pop_front();
                    if (r0_rdata !== e) begin
                        bad++;
                        $display("FAIL r0_rdata got=%h exp=%h", r0_rdata, e);
                    end
                end
                total++;
                if (cyc - g0 !== 2) begin
                    bad++;
                    $display("FAIL r0_latency got=%0d exp=2", cyc - g0);
                end
            end
            if (r1_done) begin
                total++;
                if (sb1.size() == 0) begin
                    bad++;
                    $display("FAIL r1_done_unexpected rdata=%h", r1_rdata);
                end else begin
                    logic [63:0] e;
                    e = sb1.pop_front();
                    if (r1_rdata !== e) begin
                        bad++;
                        $display("FAIL r1_rdata got=%h exp=%h", r1_rdata, e);
                    end
                end
                total++;
                if (cyc - g1 !== 2) begin
                    bad++;
                    $display("FAIL r1_latency got=%0d exp=2", cyc - g1);
                end
            end
        end
    end

    task automatic issue(input bit o, input bit we, input logic [1:0] a, input logic [63:0] d, input logic [63:0] e);
        if (o) begin
            r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
            sb1.push_back(e);
        end else begin
            r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
            sb0.push_back(e);
        end
    endtask

    task automatic wait_gnt(input bit o, output int at, output int lows);
        at = -1;
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o ? r1_gnt : r0_gnt) begin
                at = cyc;
                if (o) r1_req = 1'b0;
                else r0_req = 1'b0;
                break;
            end
            if (!busy) lows++;
        end
        if (at < 0) begin
            total++; bad++;
            $display("FAIL gnt%0d_timeout got=none exp=pulse", o);
        end
    endtask

    task automatic wait_done(input bit o);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o ? r1_done : r0_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done%0d_timeout got=none exp=pulse", o);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0_req = 1'b0; r1_req = 1'b0; b_r1_req = 1'b0;
        repeat (2) @(negedge clk);
        sb0.delete(); sb1.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if ({r0_gnt, r1_gnt} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", {r0_gnt, r1_gnt}); end
        total++; if ({r0_done, r1_done} !== 2'b00) begin bad++; $display("FAIL reset_done got=%b exp=00", {r0_done, r1_done}); end
        total++; if (rf_wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b exp=0", rf_wren); end
        total++; if (rf_dir !== 2'd0) begin bad++; $display("FAIL reset_dir got=%0d exp=0", rf_dir); end
        total++; if (rf_wdata !== 64'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
        total++; if (r0_rdata !== 64'h0 || r1_rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0", r0_rdata, r1_rdata); end
    endtask

    task automatic test_write();
        int g, l;
        bit r1_seen = 1'b0;
        issue(1'b0, 1'b1, 2'd2, 64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0003);
        wait_gnt(1'b0, g, l);
        total++; if (rf_wren !== 1'b1 || rf_dir !== 2'd2) begin bad++; $display("FAIL write_issue got=wren%b dir%0d exp=wren1 dir2", rf_wren, rf_dir); end
        total++; if (rf_wdata !== 64'hDEAD_BEEF_0000_0003) begin bad++; $display("FAIL write_wdata got=%h exp=deadbeef00000003", rf_wdata); end
        r1_seen |= r1_gnt | r1_done | (|r1_rdata);
        @(negedge clk);
        total++; if (r0_gnt !== 1'b0 || rf_wren !== 1'b0) begin bad++; $display("FAIL write_pulse got=gnt%b wren%b exp=0 0", r0_gnt, rf_wren); end
        r1_seen |= r1_gnt | r1_done | (|r1_rdata);
        @(negedge clk);
        total++; if (r0_done !== 1'b1) begin bad++; $display("FAIL write_done got=%b exp=1", r0_done); end
        r1_seen |= r1_gnt | r1_done | (|r1_rdata);
        @(negedge clk);
        total++; if (r0_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL write_end got=done%b busy%b exp=0 0", r0_done, busy); end
        r1_seen |= r1_gnt | r1_done | (|r1_rdata);
        total++; if (r1_seen !== 1'b0) begin bad++; $display("FAIL write_r1_quiet got=%b exp=0", r1_seen); end
    endtask

    task automatic test_rw_seq();
        int g, l;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b1, 2'(i), 64'(i + 1), 64'(i + 1));
            wait_gnt(1'b1, g, l);
            if (i > 0) begin
                total++; if (l !== 1) begin bad++; $display("FAIL rw_busy_gap got=%0d exp=1", l); end
            end
            wait_done(1'b1);
        end
        issue(1'b0, 1'b0, 2'd3, 64'h0, 64'd4);
        wait_gnt(1'b0, g, l);
        total++; if (l !== 1) begin bad++; $display("FAIL rd3_busy_gap got=%0d exp=1", l); end
        wait_done(1'b0);
        issue(1'b0, 1'b0, 2'd0, 64'h0, 64'd1);
        wait_gnt(1'b0, g, l);
        total++; if (l !== 1) begin bad++; $display("FAIL rd0_busy_gap got=%0d exp=1", l); end
        wait_done(1'b0);
        @(negedge clk);
        total++; if (r0_rdata !== 64'd1) begin bad++; $display("FAIL rd0_hold got=%h exp=1", r0_rdata); end
    endtask

    task automatic test_contention();
        int n = 0;
        int who [3];
        int at [3];
        int r0_seen = 0;
        do_reset();
        issue(1'b0, 1'b0, 2'd1, 64'h0, 64'd2);
        issue(1'b1, 1'b0, 2'd2, 64'h0, 64'd3);
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk);
            if (r0_gnt) begin
                who[n] = 0; at[n] = cyc; n++;
                r0_seen++;
                if (r0_seen == 1) begin
                    r0_addr = 2'd2;
                    sb0.push_back(64'd3);
                end else r0_req = 1'b0;
            end
            if (r1_gnt) begin
                who[n] = 1; at[n] = cyc; n++;
                r1_req = 1'b0;
            end
        end
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL contend_grants got=%0d exp=3", n);
            r0_req = 1'b0; r1_req = 1'b0;
        end else begin
            total++; if (who[0] !== 0 || who[1] !== 1 || who[2] !== 0) begin bad++; $display("FAIL contend_order got=%0d%0d%0d exp=010", who[0], who[1], who[2]); end
            total++; if (at[1] - at[0] !== 4 || at[2] - at[1] !== 4) begin bad++; $display("FAIL contend_spacing got=%0d,%0d exp=4,4", at[1] - at[0], at[2] - at[1]); end
            wait_done(1'b0);
        end
        total++; if (sb0.size() !== 0 || sb1.size() !== 0) begin bad++; $display("FAIL contend_drain got=%0d/%0d exp=0/0", sb0.size(), sb1.size()); end
    endtask

    task automatic test_rdlat3();
        int gb, db;
        for (int k = 0; k < 2; k++) begin
            gb = -1; db = -1;
            @(negedge clk);
            b_r1_req = 1'b1; b_r1_we = (k == 0); b_r1_addr = 2'd1; b_r1_wdata = (k == 0) ? 64'h5 : 64'h0;
            for (int i = 0; i < 40 && db < 0; i++) begin
                @(negedge clk);
                if (b_r1_gnt) begin gb = cyc; b_r1_req = 1'b0; end
                if (b_r1_done) db = cyc;
            end
            b_r1_req = 1'b0;
            total++; if (gb < 0 || db - gb !== 4) begin bad++; $display("FAIL lat3_%0d got=%0d exp=4", k, db - gb); end
            total++; if (b_r1_rdata !== 64'h5) begin bad++; $display("FAIL lat3_rdata_%0d got=%h exp=5", k, b_r1_rdata); end
        end
    endtask

    task automatic test_reset_mid();
        int g, l;
        bit seen = 1'b0;
        issue(1'b0, 1'b0, 2'd3, 64'h0, 64'd4);
        wait_gnt(1'b0, g, l);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb0.delete();
        total++; if (r0_done !== 1'b0 || r0_rdata !== 64'h0) begin bad++; $display("FAIL abort_r0 got=done%b rdata%h exp=0 0", r0_done, r0_rdata); end
        total++; if (busy !== 1'b0 || rf_wren !== 1'b0) begin bad++; $display("FAIL abort_busy got=busy%b wren%b exp=0 0", busy, rf_wren); end
        repeat (5) begin
            @(negedge clk);
            seen |= r0_done;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", seen); end
        issue(1'b1, 1'b0, 2'd0, 64'h0, 64'd1);
        wait_gnt(1'b1, g, l);
        wait_done(1'b1);
        @(negedge clk);
        issue(1'b0, 1'b0, 2'd1, 64'h0, 64'd2);
        issue(1'b1, 1'b0, 2'd2, 64'h0, 64'd3);
        wait_gnt(1'b0, g, l);
        total++; if (r1_gnt !== 1'b0) begin bad++; $display("FAIL post_abort_winner got=r1 exp=r0"); end
        wait_gnt(1'b1, g, l);
        wait_done(1'b1);
    endtask

    task automatic test_ignore_busy();
        int g, l;
        bit seen = 1'b0;
        @(negedge clk);
        issue(1'b0, 1'b0, 2'd2, 64'h0, 64'd3);
        wait_gnt(1'b0, g, l);
        @(negedge clk);
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 2'd1;
        @(negedge clk);
        r1_req = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= r1_gnt | r1_done;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL busy_pulse_ignored got=%b exp=0", seen); end
        total++; if (r1_rdata !== 64'd3) begin bad++; $display("FAIL busy_r1_hold got=%h exp=3", r1_rdata); end
        total++; if (sb0.size() !== 0) begin bad++; $display("FAIL busy_r0_served got=%0d exp=0", sb0.size()); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_rw_seq();
        test_contention();
        test_rdlat3();
        test_reset_mid();
        test_ignore_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
